chip_top: RTL and testbench



---
 rtl/chip_top.sv | 246 ++++++++++++++++++++++++
 tb/tb_chip_top.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip_top.sv
// chip_top: UART-fed 3x3 Sobel/Prewitt edge detector returning one gradient byte per pixel over UART.
// Build option: define EDGE_THRESHOLD_EN to binarise non-border outputs against THRESHOLD.
module chip_top #(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned IMG_W        = 512,
  parameter int unsigned IMG_H        = 512,
  parameter logic [7:0]  THRESHOLD    = 8'h80,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       rx,
  output logic       tx,
  input  logic       kernel_select,
  input  logic [1:0] fill_select
);
  // state | meaning (RX and TX): IDLE line idle | START start bit | DATA 8 bits LSB first | STOP stop bit
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCN_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FCN_W-1:0] FIFO_FULL = FCN_W'(FIFO_DEPTH);
`ifdef EDGE_THRESHOLD_EN
  localparam bit BINARISE = 1'b1;
`else
  localparam bit BINARISE = 1'b0;
`endif

  uart_state_e      rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [2:0]       rx_sync_q, rx_sync_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d, tx_idx_q, tx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d, pix_valid, fifo_pop, fifo_push;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [2:0][1:0][7:0] win_q, win_d;
  logic [2:0][2:0][7:0] p;
  logic [7:0]       res_q, res_d, fill_val, sat, edge_val;
  logic             res_vld_q, res_vld_d;
  logic [11:0]      sx_pos, sx_neg, sy_pos, sy_neg, abs_x, abs_y, mag;
  logic signed [11:0] gx, gy;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCN_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [7:0]       lb_near [IMG_W];
  logic [7:0]       lb_far  [IMG_W];
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  function automatic logic [11:0] zx(input logic [7:0] v);
    return {4'b0000, v};
  endfunction

  function automatic logic [11:0] wt(input logic [7:0] v, input logic prewitt);
    return prewitt ? {4'b0000, v} : {3'b000, v, 1'b0};
  endfunction

  assign tx = tx_q;

  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], rx};
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    pix_valid  = 1'b0;
    if (rx_state_q != S_IDLE) rx_cnt_d = rx_cnt_q - 1'b1;
    case (rx_state_q)
      S_IDLE: if (rx_sync_q[2] && !rx_sync_q[1]) begin
        rx_state_d = S_START;
        rx_cnt_d   = HALF_TC;
      end
      S_START: if (rx_cnt_q == '0) begin
        rx_state_d = rx_sync_q[1] ? S_IDLE : S_DATA;
        rx_cnt_d   = BIT_TC;
        rx_idx_d   = 3'd0;
      end
      S_DATA: if (rx_cnt_q == '0) begin
        rx_shift_d = {rx_sync_q[1], rx_shift_q[7:1]};
        rx_cnt_d   = BIT_TC;
        rx_idx_d   = rx_idx_q + 1'b1;
        if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
      end
      default: if (rx_cnt_q == '0) begin
        pix_valid  = rx_sync_q[1];
        rx_state_d = S_IDLE;
      end
    endcase
  end

  // Window columns 0/1 are registered (c-2, c-1); column 2 is the live column for pixel c.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      p[i][0] = win_q[i][0];
      p[i][1] = win_q[i][1];
    end
    p[0][2] = lb_far[col_q];
    p[1][2] = lb_near[col_q];
    p[2][2] = rx_shift_q;
    sx_pos = zx(p[0][2]) + wt(p[1][2], kernel_select) + zx(p[2][2]);
    sx_neg = zx(p[0][0]) + wt(p[1][0], kernel_select) + zx(p[2][0]);
    sy_pos = zx(p[2][0]) + wt(p[2][1], kernel_select) + zx(p[2][2]);
    sy_neg = zx(p[0][0]) + wt(p[0][1], kernel_select) + zx(p[0][2]);
    gx     = $signed(sx_pos - sx_neg);
    gy     = $signed(sy_pos - sy_neg);
    abs_x  = gx[11] ? 12'(-gx) : 12'(gx);
    abs_y  = gy[11] ? 12'(-gy) : 12'(gy);
    mag    = abs_x + abs_y;
    sat    = (mag[11:8] != 4'd0) ? 8'hFF : mag[7:0];
    edge_val = BINARISE ? ((sat >= THRESHOLD) ? 8'hFF : 8'h00) : sat;
    case (fill_select)
      2'd0:    fill_val = 8'h00;
      2'd1:    fill_val = 8'hFF;
      2'd2:    fill_val = rx_shift_q;
      default: fill_val = 8'h80;
    endcase
    win_d     = win_q;
    col_d     = col_q;
    row_d     = row_q;
    res_d     = res_q;
    res_vld_d = pix_valid;
    if (pix_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = p[i][2];
      end
      res_d = (row_q < ROW_W'(2) || col_q < COL_W'(2)) ? fill_val : edge_val;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_cnt_q - 1'b1;
    if ((tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_cnt_q == '0)) && fifo_cnt_q != '0) begin
      fifo_pop   = 1'b1;
      tx_shift_d = fifo_mem[rd_ptr_q];
      tx_state_d = S_START;
      tx_cnt_d   = BIT_TC;
      tx_d       = 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: tx_d = 1'b1;
        S_START: if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = BIT_TC;
          tx_idx_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end
        S_DATA: if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_TC;
          tx_idx_d   = tx_idx_q + 1'b1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_d       = tx_shift_q[1];
          if (tx_idx_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end
        end
        default: if (tx_cnt_q == '0) tx_state_d = S_IDLE;
      endcase
    end
  end

  // A push into a full queue only lands when the same cycle also pops.
  always_comb begin
    fifo_push  = res_vld_q && ((fifo_cnt_q != FIFO_FULL) || fifo_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (fifo_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_near[col_q] <= rx_shift_q;
      lb_far[col_q]  <= lb_near[col_q];
    end
    if (fifo_push) fifo_mem[wr_ptr_q] <= res_q;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      rx_state_q <= S_IDLE;
      tx_state_q <= S_IDLE;
      rx_sync_q  <= 3'b111;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      tx_idx_q   <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_sync_q  <= rx_sync_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      tx_idx_q   <= tx_idx_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      res_q      <= res_d;
      res_vld_q  <= res_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end
endmodule

// File: tb/tb_chip_top.sv
// Bench for chip_top: 8x8 image over UART, outputs decoded from tx and compared with a 2-D convolution model.
module tb_chip_top;
  localparam int CPB = 8;
  localparam int W = 8;
  localparam int H = 8;
  localparam logic [7:0] THR = 8'h30;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic       kernel_select = 1'b0;
  logic [1:0] fill_select = 2'd0;

  chip_top #(.CLKS_PER_BIT(CPB), .IMG_W(W), .IMG_H(H), .THRESHOLD(THR), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstN(rstN), .rx(rx), .tx(tx),
    .kernel_select(kernel_select), .fill_select(fill_select)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frame_errs = 0;
  bit mon_en = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] img [H][W];
  int mr = 0;
  int mc = 0;

  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
          end
          repeat (CPB) @(negedge clk);
          if (tx !== 1'b1) frame_errs++;
          else got_q.push_back(b);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Model: keep the frame as a 2-D array and convolve the 3x3 neighbourhood ending at (mr, mc).
  task automatic send_pix(input logic [7:0] pix);
    int gx, gy, v, wx, wy, cw, mag;
    logic [7:0] e;
    img[mr][mc] = pix;
    if (mr < 2 || mc < 2) begin
      case (fill_select)
        2'd0:    e = 8'h00;
        2'd1:    e = 8'hFF;
        2'd2:    e = pix;
        default: e = 8'h80;
      endcase
    end else begin
      cw = kernel_select ? 1 : 2;
      gx = 0;
      gy = 0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          v  = int'(img[mr - 2 + i][mc - 2 + j]);
          wx = (j - 1) * ((i == 1) ? cw : 1);
          wy = (i - 1) * ((j == 1) ? cw : 1);
          gx += wx * v;
          gy += wy * v;
        end
      end
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
`ifdef EDGE_THRESHOLD_EN
      e = (mag >= int'(THR)) ? 8'hFF : 8'h00;
`else
      e = 8'(mag);
`endif
    end
    exp_q.push_back(e);
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
    send_byte(pix, 1'b1);
  endtask

  task automatic check_outputs(input string tag);
    int t;
    logic [7:0] g, e;
    int idx;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 40 * CPB) begin
      @(negedge clk);
      t++;
    end
    checks++;
    assert (got_q.size() === exp_q.size()) else begin
      errors++;
      $error("FAIL %s_count got=%0d exp=%0d", tag, got_q.size(), exp_q.size());
    end
    idx = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      assert (g === e) else begin
        errors++;
        $error("FAIL %s[%0d] got=%h exp=%h", tag, idx, g, e);
      end
      idx++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit any_low;
    int t;
    @(negedge clk);
    rstN = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    assert (tx === 1'b1) else begin
      errors++;
      $error("FAIL reset_tx got=%b exp=1", tx);
    end
    rstN   = 1'b1;
    mon_en = 1'b1;
    any_low = 1'b0;
    repeat (30 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1) any_low = 1'b1;
    end
    checks++;
    assert (any_low === 1'b0) else begin
      errors++;
      $error("FAIL idle_tx got_low=%b exp=0", any_low);
    end
    check_outputs("idle");

    kernel_select = 1'b0;
    fill_select   = 2'd0;
    for (int i = 0; i < W * H; i++) send_pix(8'h80);
    check_outputs("uniform");

    for (int k = 0; k < 2; k++) begin
      kernel_select = k[0];
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) send_pix((c >= 4) ? 8'h10 : 8'h00);
      check_outputs(k == 0 ? "step_sobel" : "step_prewitt");
    end

    kernel_select = 1'b0;
    for (int f = 1; f < 4; f++) begin
      fill_select = 2'(f);
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) send_pix((c >= 4) ? 8'h10 : 8'h00);
      check_outputs("step_fill");
    end

    for (int i = 0; i < W * H; i++) begin
      kernel_select = 1'($urandom_range(0, 1));
      fill_select   = 2'($urandom_range(0, 3));
      send_pix(8'($urandom));
    end
    check_outputs("random");

    send_byte(8'hA5, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    check_outputs("bad_stop");

    kernel_select = 1'b0;
    fill_select   = 2'd3;
    for (int i = 0; i < W * H + 1; i++) send_pix(8'($urandom));
    check_outputs("wrap");

    send_pix(8'h3C);
    t = 0;
    while (tx !== 1'b0 && t < 20 * CPB) begin
      @(negedge clk);
      t++;
    end
    checks++;
    assert (tx === 1'b0) else begin
      errors++;
      $error("FAIL tx_start got=%b exp=0", tx);
    end
    rstN = 1'b0;
    @(negedge clk);
    checks++;
    assert (tx === 1'b1) else begin
      errors++;
      $error("FAIL midreset_tx got=%b exp=1", tx);
    end
    rstN = 1'b1;
    mr = 0;
    mc = 0;
    exp_q.delete();
    repeat (12 * CPB) @(negedge clk);
    got_q.delete();
    for (int i = 0; i < 24; i++) begin
      kernel_select = 1'($urandom_range(0, 1));
      fill_select   = 2'($urandom_range(0, 3));
      send_pix(8'($urandom));
    end
    check_outputs("after_reset");

    checks++;
    assert (frame_errs === 0) else begin
      errors++;
      $error("FAIL tx_framing got=%0d exp=0", frame_errs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
